bram_mat_ctrl: RTL

BRAM_MAT_CTRL -- requirements
Module: bram_mat_ctrl

---
 rtl/bram_mat_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/bram_mat_ctrl.sv
// -----------------------------------------------------------------------------
// bram_mat_ctrl
//   Sequencer between a single-port BRAM and a ROWS x COLS systolic array.
//   One job is four phases:
//     1. ROWS weight lines are loaded from addresses 0..ROWS-1.
//     2. ROWS+COLS-1 input lines are streamed from ROWS..2*ROWS+COLS-2.
//     3. ROWS result lines are captured from the array.
//     4. The result lines are written back to OUT_BASE..OUT_BASE+ROWS-1.
//   The BRAM returns read data one cycle after the address, so w_valid and
//   in_valid are registered copies of the issuing phase. The data itself is
//   taken directly from mem_dout.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle pulse; honoured only in IDLE
//   busy, done           job in progress / one-cycle completion pulse
//   mem_addr, mem_we,    BRAM master port (read latency 1)
//   mem_di, mem_dout
//   w_valid, w_row,      weight-line load toward the array
//   w_data
//   in_valid, in_data    staggered input-line stream toward the array
//   res_valid, res_data  result lines from the array
//   cyc_cnt              busy-cycle counter; present only when the macro
//                        BRAM_MAT_CTRL_CYC_CNT_EN is defined
// -----------------------------------------------------------------------------
module bram_mat_ctrl #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WORD_SIZE = 32,
    parameter int OUT_BASE  = 2 * ROWS + COLS - 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [31:0]                   mem_addr,
    output logic                          mem_we,
    output logic [COLS*WORD_SIZE-1:0]     mem_di,
    input  logic [COLS*WORD_SIZE-1:0]     mem_dout,
    output logic                          w_valid,
    output logic [$clog2(ROWS)-1:0]       w_row,
    output logic [COLS*WORD_SIZE-1:0]     w_data,
    output logic                          in_valid,
    output logic [COLS*WORD_SIZE-1:0]     in_data,
    input  logic                          res_valid,
    input  logic [COLS*WORD_SIZE-1:0]     res_data
`ifdef BRAM_MAT_CTRL_CYC_CNT_EN
    ,
    output logic [31:0]                   cyc_cnt
`endif
);

    localparam int LW = COLS * WORD_SIZE;
    localparam int RW = $clog2(ROWS);
    localparam int IW = $clog2(2 * ROWS + COLS);   // covers every phase index
    localparam int CW = $clog2(ROWS + 1);          // capture count 0..ROWS

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [IW-1:0]   idx, idx_next;
    logic [CW-1:0]   cap_cnt;
    logic            start_accept;
    logic            capture;
    logic            full_now;
    logic [LW-1:0]   res_buf [ROWS];

    // A beat is kept only while the array is producing results and the
    // buffer still has room; anything else is silently dropped.
    assign capture  = res_valid && (state == STREAM || state == COLLECT)
                      && (cap_cnt < CW'(ROWS));
    // Buffer is full at the end of this cycle, counting a beat arriving now.
    assign full_now = (cap_cnt == CW'(ROWS))
                      || (capture && cap_cnt == CW'(ROWS - 1));

    // Read data is passed straight through; the valids mark which is which.
    assign w_data  = mem_dout;
    assign in_data = mem_dout;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            cap_cnt  <= '0;
            w_valid  <= 1'b0;
            w_row    <= '0;
            in_valid <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            // Address issued this cycle returns data next cycle.
            w_valid  <= (state == LOAD_W);
            in_valid <= (state == STREAM);
            if (state == LOAD_W) begin
                w_row <= idx[RW-1:0];
            end
            if (start_accept) begin
                cap_cnt <= '0;
            end else if (capture) begin
                cap_cnt <= cap_cnt + CW'(1);
            end
        end
    end

    // NOTE: the result buffer is storage, not control state, so it has no
    // reset; its contents are only read after ROWS fresh beats are captured.
    always_ff @(posedge clk) begin
        if (capture) begin
            res_buf[cap_cnt[RW-1:0]] <= res_data;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        start_accept = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = LOAD_W;
                    idx_next     = '0;
                    start_accept = 1'b1;
                end
            end
            LOAD_W: begin
                // Falls straight into STREAM so the last weight line and the
                // first input line are back to back.
                if (idx == IW'(ROWS - 1)) begin
                    state_next = STREAM;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + IW'(1);
                end
            end
            STREAM: begin
                if (idx == IW'(ROWS + COLS - 2)) begin
                    idx_next   = '0;
                    state_next = full_now ? WRITE : COLLECT;
                end else begin
                    idx_next = idx + IW'(1);
                end
            end
            COLLECT: begin
                if (full_now) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (idx == IW'(ROWS - 1)) begin
                    state_next = DONE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + IW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Outputs decoded from state; busy is already low in the DONE cycle.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_di   = '0;
        case (state)
            LOAD_W: begin
                busy     = 1'b1;
                mem_addr = 32'(idx);
            end
            STREAM: begin
                busy     = 1'b1;
                mem_addr = 32'(ROWS) + 32'(idx);
            end
            COLLECT: begin
                busy = 1'b1;
            end
            WRITE: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = 32'(OUT_BASE) + 32'(idx);
                mem_di   = res_buf[idx[RW-1:0]];
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

`ifdef BRAM_MAT_CTRL_CYC_CNT_EN
    // Counts busy cycles of the current job and holds afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else if (start_accept) begin
            cyc_cnt <= '0;
        end else if (busy) begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end
`endif

endmodule
